trig_surround_cache_p: RTL and testbench

Parametrised trigger-surround cache. Pulls samples from the ADC over a req/rdy handshake into a DEPTH-entry ring buffer and fires on a threshold crossing (rising or falling). It keeps PRE samples before the trigger and DEPTH-PRE samples from the trigger on, then serialises the window MSB-first on sd when requested. Sits between the ADC model and the serial readout path.

---
 rtl/tsc_pkg.sv | 16 +
 rtl/tsc_serializer.sv | 53 +++++
 rtl/trig_surround_cache_p.sv | 163 ++++++++++++++++
 tb/tb_trig_surround_cache_p.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsc_pkg.sv
// Shared state encoding and edge-select constants for the trigger-surround cache.
package tsc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREFILL = 3'd1,
    RUN     = 3'd2,
    POST    = 3'd3,
    HOLD    = 3'd4,
    SEND    = 3'd5
  } state_t;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/tsc_serializer.sv
// MSB-first word serializer; with TSC_PARITY_EN defined each word is followed
// by its even-parity bit. word_done marks the last bit of the current word.
module tsc_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  output logic              sd,
  output logic              sd_vld,
  output logic              word_done
);

`ifdef TSC_PARITY_EN
  localparam int BITS = DATA_W + 1;
`else
  localparam int BITS = DATA_W;
`endif
  localparam int CNT_W = $clog2(BITS);

  logic [BITS-1:0]  sh;
  logic [BITS-1:0]  sh_load;
  logic [CNT_W-1:0] cnt;
  logic             busy;

`ifdef TSC_PARITY_EN
  assign sh_load = {word, ^word};
`else
  assign sh_load = word;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      sh   <= sh_load;
      cnt  <= CNT_W'(BITS - 1);
      busy <= 1'b1;
    end else if (busy) begin
      sh <= {sh[BITS-2:0], 1'b0};
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

  assign sd        = busy & sh[BITS-1];
  assign sd_vld    = busy;
  assign word_done = busy && (cnt == '0);

endmodule

// File: rtl/trig_surround_cache_p.sv
// Trigger-surround cache: ring-buffers ADC samples, freezes a PRE/post window
// around a threshold crossing and serialises it. Optional parity: TSC_PARITY_EN.
module trig_surround_cache_p
  import tsc_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 32,
  parameter int PRE     = 8,
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               sbf,
  input  logic [DATA_W-1:0]  thresh,
  input  logic               edge_sel,
  output logic               req,
  input  logic               rdy,
  input  logic [DATA_W-1:0]  adc_data,
  output logic               trd,
  output logic [TIMER_W-1:0] trigtm,
  output logic               sd,
  output logic               sd_vld,
  output logic               cd
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PRE_V  = PTR_W'(PRE);
  localparam logic [PTR_W-1:0] POST_V = PTR_W'(DEPTH - PRE - 1);
  localparam logic [PTR_W-1:0] LAST_W = PTR_W'(DEPTH - 1);

  state_t state, state_nxt;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [TIMER_W-1:0] timer;
  logic [DATA_W-1:0]  thresh_q, prev;
  logic               edge_q;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, trig_ptr, fill, post_cnt, words_left;
  logic [PTR_W-1:0]   fill_inc, start_ptr;
  logic               accept, hit, arm;
  logic               ser_load, word_done, cd_nxt;
  logic [DATA_W-1:0]  ser_word;

  assign accept    = req & rdy;
  assign fill_inc  = fill + 1'b1;
  assign start_ptr = trig_ptr - PRE_V;
  assign arm       = (state_nxt == PREFILL) && (state != PREFILL);
  assign ser_word  = (state == SEND) ? mem[rd_ptr] : mem[start_ptr];

  always_comb begin
    hit = 1'b0;
    if (edge_q == EDGE_RISE) hit = (prev <  thresh_q) && (adc_data >= thresh_q);
    if (edge_q == EDGE_FALL) hit = (prev >= thresh_q) && (adc_data <  thresh_q);
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    ser_load  = 1'b0;
    cd_nxt    = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = PREFILL;
      PREFILL: begin
        req = 1'b1;
        if (accept && fill_inc == PRE_V) state_nxt = RUN;
      end
      RUN: begin
        req = 1'b1;
        if (accept && hit) state_nxt = (POST_V == '0) ? HOLD : POST;
      end
      POST: begin
        req = 1'b1;
        if (accept && post_cnt == PTR_W'(1)) state_nxt = HOLD;
      end
      // sbf takes priority over a simultaneous re-arm
      HOLD: begin
        if (sbf) begin
          state_nxt = SEND;
          ser_load  = 1'b1;
        end else if (start) begin
          state_nxt = PREFILL;
        end
      end
      SEND: begin
        if (word_done) begin
          if (words_left != '0) begin
            ser_load = 1'b1;
          end else begin
            state_nxt = IDLE;
            cd_nxt    = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      trig_ptr   <= '0;
      fill       <= '0;
      post_cnt   <= '0;
      words_left <= '0;
      thresh_q   <= '0;
      edge_q     <= 1'b0;
      prev       <= '0;
      trd        <= 1'b0;
      trigtm     <= '0;
      cd         <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer + 1'b1;
      cd    <= cd_nxt;
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        prev   <= adc_data;
      end
      if (arm) begin
        thresh_q <= thresh;
        edge_q   <= edge_sel;
        trd      <= 1'b0;
        fill     <= '0;
      end
      if (state == PREFILL && accept) fill <= fill_inc;
      if (state == RUN && accept && hit) begin
        trd      <= 1'b1;
        trigtm   <= timer;
        trig_ptr <= wr_ptr;
        post_cnt <= POST_V;
      end
      if (state == POST && accept) post_cnt <= post_cnt - 1'b1;
      if (ser_load) begin
        if (state == HOLD) begin
          rd_ptr     <= start_ptr + 1'b1;
          words_left <= LAST_W;
        end else begin
          rd_ptr     <= rd_ptr + 1'b1;
          words_left <= words_left - 1'b1;
        end
      end
    end
  end

  // Sample storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= adc_data;
  end

  tsc_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .word      (ser_word),
    .sd        (sd),
    .sd_vld    (sd_vld),
    .word_done (word_done)
  );

endmodule

// File: tb/tb_trig_surround_cache_p.sv
// Self-checking bench for trig_surround_cache_p: table of capture scenarios,
// window contents checked through an expected-word scoreboard.
`timescale 1ns/1ps
module tb_trig_surround_cache_p;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 32;
  localparam int PRE     = 8;
  localparam int TIMER_W = 32;
`ifdef TSC_PARITY_EN
  localparam int BITS = DATA_W + 1;
`else
  localparam int BITS = DATA_W;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0, sbf = 1'b0, edge_sel = 1'b0, rdy = 1'b0;
  logic [DATA_W-1:0]  thresh = '0, adc_data = '0;
  logic               req, trd, sd, sd_vld, cd;
  logic [TIMER_W-1:0] trigtm;

  always #5 clk = ~clk;

  trig_surround_cache_p #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .PRE(PRE), .TIMER_W(TIMER_W)
  ) dut (
    .clk(clk), .reset(rst), .start(start), .sbf(sbf), .thresh(thresh),
    .edge_sel(edge_sel), .req(req), .rdy(rdy), .adc_data(adc_data),
    .trd(trd), .trigtm(trigtm), .sd(sd), .sd_vld(sd_vld), .cd(cd)
  );

  // reference free-running timer
  logic [TIMER_W-1:0] tb_timer;
  always @(posedge clk or posedge rst)
    if (rst) tb_timer <= '0;
    else     tb_timer <= tb_timer + 1'b1;

  typedef struct {
    logic       edge_v;
    logic [7:0] th;
    logic [7:0] base;
    logic [7:0] step;
    int         a1_idx;
    logic [7:0] a1_val;
    int         a2_idx;
    logic [7:0] a2_val;
    int         gap_idx;
    bit         rnd_stall;
    bit         poke;
    int         hold_op;   // 0 sbf, 1 sbf+start, 2 start, 3 reset mid-send
    int         exp_idx;   // -1: no trigger expected
  } vec_t;

  vec_t vecs[7];
  int checks = 0;
  int errors = 0;
  logic [7:0] hist[$];
  logic [BITS-1:0] exp_q[$];
  int n;
  int gap_left;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] samp(input vec_t v, input int i);
    if (i == v.a1_idx) return v.a1_val;
    if (i == v.a2_idx) return v.a2_val;
    return v.base + 8'(i) * v.step;
  endfunction

  function automatic logic [BITS-1:0] exp_bits(input logic [7:0] w);
`ifdef TSC_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 0; sbf = 0; rdy = 0; adc_data = '0; thresh = '0; edge_sel = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_req", req, 0);
    check("rst_trd", trd, 0);
    check("rst_trigtm", trigtm, 0);
    check("rst_sd_vld", {sd, sd_vld}, 0);
    check("rst_cd", cd, 0);
  endtask

  task automatic drive_one(input vec_t v, output bit acc, output logic [TIMER_W-1:0] tm);
    if (n == v.gap_idx && gap_left > 0) begin
      rdy = 1'b0;
      gap_left--;
    end else if (v.rnd_stall && $urandom_range(0, 2) == 0) begin
      rdy = 1'b0;
    end else begin
      rdy = 1'b1;
    end
    adc_data = samp(v, n);
    start = v.poke && (n == 3 || n == 10 || n == 18);
    sbf   = v.poke && (n == 3 || n == 10 || n == 18);
    acc = rdy && req;
    tm  = tb_timer;
    tick();
    start = 1'b0;
    sbf   = 1'b0;
    if (acc) begin
      hist.push_back(adc_data);
      n++;
    end
  endtask

  task automatic run_row(input vec_t v, input int r);
    bit acc;
    logic [TIMER_W-1:0] tm, trig_tm;
    int trig_idx, post_acc, vld_cnt, cd_cnt, cd_at, bitcnt;
    logic [BITS-1:0] got;

    do_reset();
    hist.delete();
    exp_q.delete();
    n = 0;
    gap_left = 5;
    thresh = v.th;
    edge_sel = v.edge_v;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("arm_req", req, 1);

    trig_idx = -1;
    trig_tm  = '0;
    for (int k = 0; k < 120 && trig_idx == -1 && n < 48; k++) begin
      drive_one(v, acc, tm);
      if (trd) begin
        trig_idx = acc ? n - 1 : -2;
        trig_tm  = tm;
      end
    end
    rdy = 1'b0;
    check($sformatf("trig_idx_r%0d", r), trig_idx, v.exp_idx);
    if (v.exp_idx < 0) begin
      check("notrig_trd", trd, 0);
      check("notrig_req", req, 1);
      return;
    end
    if (trig_idx < PRE) return;
    check("trigtm", trigtm, trig_tm);

    post_acc = 0;
    for (int k = 0; k < 200 && post_acc < DEPTH - PRE - 1 && req; k++) begin
      drive_one(v, acc, tm);
      if (acc) post_acc++;
    end
    rdy = 1'b0;
    check("post_count", post_acc, DEPTH - PRE - 1);
    check("hold_req", req, 0);
    check("trd_held", trd, 1);
    check("trigtm_hold", trigtm, trig_tm);

    if (v.hold_op == 2) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      check("rearm_req", req, 1);
      check("rearm_trd", trd, 0);
      check("rearm_no_send", sd_vld, 0);
      return;
    end

    for (int j = 0; j < DEPTH; j++) exp_q.push_back(exp_bits(hist[trig_idx - PRE + j]));
    sbf   = 1'b1;
    start = (v.hold_op == 1);
    tick();
    sbf   = 1'b0;
    start = 1'b0;
    check("first_vld", sd_vld, 1);

    vld_cnt = 0; cd_cnt = 0; cd_at = -1; bitcnt = 0; got = '0;
    for (int k = 0; k < DEPTH * BITS + 8; k++) begin
      if (sd_vld) begin
        got = {got[BITS-2:0], sd};
        bitcnt++;
        vld_cnt++;
        if (bitcnt == BITS) begin
          bitcnt = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow got word %0h expected none", got);
          end else begin
            check("word", got, exp_q.pop_front());
          end
        end
      end
      if (cd) begin
        cd_cnt++;
        cd_at = k;
      end
      if (v.hold_op == 3 && k == 50) break;
      start = (v.hold_op == 0 && k == 40);
      tick();
      start = 1'b0;
    end

    if (v.hold_op == 3) begin
      #3 rst = 1'b1;
      #1;
      check("mid_rst_vld", sd_vld, 0);
      check("mid_rst_cd", cd, 0);
      check("mid_rst_trd", trd, 0);
      check("mid_rst_req", req, 0);
      tick();
      tick();
      check("mid_rst_quiet", {cd, sd_vld}, 0);
      return;
    end

    check("vld_cnt", vld_cnt, DEPTH * BITS);
    check("cd_cnt", cd_cnt, 1);
    check("cd_at", cd_at, DEPTH * BITS);
    check("sb_left", exp_q.size(), 0);
    check("send_trd", trd, 1);
    check("idle_req", req, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("idle_rearm", {req, trd}, 2'b10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    //          edge  th     base   step   a1  a1v    a2  a2v    gap rnd poke hold exp
    vecs[0] = '{1'b0, 8'hD5, 8'h00, 8'h10, -1, 8'h00, -1, 8'h00, 20, 0, 1, 0, 14};
    vecs[1] = '{1'b1, 8'h40, 8'h80, 8'h00, 12, 8'h30, -1, 8'h00, -1, 0, 0, 1, 12};
    vecs[2] = '{1'b0, 8'h50, 8'h00, 8'h00,  2, 8'h60, 10, 8'h60, -1, 0, 0, 0, 10};
    vecs[3] = '{1'b1, 8'h80, 8'hF0, 8'hF0, -1, 8'h00, -1, 8'h00, -1, 0, 0, 0,  8};
    vecs[4] = '{1'b0, 8'h00, 8'h00, 8'h10, -1, 8'h00, -1, 8'h00, -1, 0, 0, 0, -1};
    vecs[5] = '{1'b0, 8'h80, 8'h7F, 8'h00,  8, 8'h80, -1, 8'h00, -1, 1, 0, 2,  8};
    vecs[6] = '{1'b0, 8'hD5, 8'h00, 8'h10, -1, 8'h00, -1, 8'h00, -1, 0, 0, 3, 14};

    // sbf while idle must not start a transfer
    do_reset();
    sbf = 1'b1;
    tick();
    sbf = 1'b0;
    check("idle_sbf_vld", sd_vld, 0);
    check("idle_sbf_req", req, 0);

    for (int r = 0; r < 7; r++) run_row(vecs[r], r);

    rst = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
